pmem_writeback_buffer: RTL and testbench

//  One-entry write-back (victim) buffer and sequencer between the L2/arbiter side and physical memory.

---
 rtl/pmem_writeback_buffer.sv | 129 ++++++++++++
 tb/tb_pmem_writeback_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_writeback_buffer.sv
// One-entry victim buffer between L2/arbiter and physical memory.
// Dirty writes are absorbed immediately and drained to pmem when upstream goes idle or a conflicting write arrives.
module pmem_writeback_buffer #(
  parameter int ADDR_W     = 16,
  parameter int LINE_W     = 128,
  parameter int OFFSET_W   = 4,
  parameter int DRAIN_IDLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ul_read,
  input  logic              ul_write,
  input  logic [ADDR_W-1:0] ul_address,
  input  logic [LINE_W-1:0] ul_wdata,
  output logic [LINE_W-1:0] ul_rdata,
  output logic              ul_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int CNT_W = (DRAIN_IDLE > 0) ? $clog2(DRAIN_IDLE + 1) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{TAG_W{1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ_MISS, S_DRAIN, S_RESP} state_t;

  state_t             state, state_nxt;
  logic               buf_valid;
  logic [TAG_W-1:0]   buf_tag;
  logic [LINE_W-1:0]  buf_data;
  logic [CNT_W-1:0]   idle_cnt;
  logic [LINE_W-1:0]  rdata_q;

  logic tag_match, hit;
  logic buf_wr, buf_clr, rd_from_buf, rd_from_pmem, cnt_clr, cnt_inc;

  assign tag_match = (ul_address[ADDR_W-1:OFFSET_W] == buf_tag);
  assign hit       = buf_valid && tag_match;

  always_comb begin
    state_nxt    = state;
    buf_wr       = 1'b0;
    buf_clr      = 1'b0;
    rd_from_buf  = 1'b0;
    rd_from_pmem = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ul_read || ul_write || !buf_valid) cnt_clr = 1'b1;
        if (ul_read) begin
          if (hit) begin
            rd_from_buf = 1'b1;
            state_nxt   = S_RESP;
          end else begin
            state_nxt = S_READ_MISS;
          end
        end else if (ul_write) begin
          // A conflicting write drains first, then is re-evaluated back in IDLE.
          if (!buf_valid || tag_match) begin
            buf_wr    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else if (buf_valid) begin
          if (idle_cnt == CNT_W'(DRAIN_IDLE)) state_nxt = S_DRAIN;
          else                                cnt_inc   = 1'b1;
        end
      end
      S_READ_MISS: begin
        if (pmem_resp) begin
          rd_from_pmem = 1'b1;
          state_nxt    = S_RESP;
        end
      end
      S_DRAIN: begin
        if (pmem_resp) begin
          buf_clr   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      idle_cnt  <= '0;
      rdata_q   <= '0;
    end else begin
      if (buf_wr) begin
        buf_valid <= 1'b1;
        buf_tag   <= ul_address[ADDR_W-1:OFFSET_W];
        buf_data  <= ul_wdata;
      end else if (buf_clr) begin
        buf_valid <= 1'b0;
      end
      if (cnt_clr)      idle_cnt <= '0;
      else if (cnt_inc) idle_cnt <= idle_cnt + 1'b1;
      if (rd_from_buf)       rdata_q <= buf_data;
      else if (rd_from_pmem) rdata_q <= pmem_rdata;
    end
  end

  // Outputs decode straight from state so an async reset drops them the same cycle.
  assign pmem_read    = (state == S_READ_MISS);
  assign pmem_write   = (state == S_DRAIN);
  assign pmem_address = (state == S_READ_MISS) ? (ul_address & LINE_MASK) :
                        (state == S_DRAIN)     ? {buf_tag, {OFFSET_W{1'b0}}} : '0;
  assign pmem_wdata   = (state == S_DRAIN) ? buf_data : '0;
  assign ul_resp      = (state == S_RESP);
  assign ul_rdata     = (state == S_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_pmem_writeback_buffer.sv
// Randomized + directed bench for pmem_writeback_buffer against a transaction-level buffer/memory model.
module tb_pmem_writeback_buffer;
  localparam int AW = 16, LW = 128, OW = 4, DI = 3;

  logic          clk = 1'b0, rst;
  logic          ul_read, ul_write, ul_resp, pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] ul_address, pmem_address;
  logic [LW-1:0] ul_wdata, ul_rdata, pmem_wdata, pmem_rdata;

  pmem_writeback_buffer #(.ADDR_W(AW), .LINE_W(LW), .OFFSET_W(OW), .DRAIN_IDLE(DI)) dut (
    .clk(clk), .rst(rst),
    .ul_read(ul_read), .ul_write(ul_write), .ul_address(ul_address), .ul_wdata(ul_wdata),
    .ul_rdata(ul_rdata), .ul_resp(ul_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input int t);
    return {4{(32'(t) * 32'h9E3779B1) ^ 32'h5A5A0000}};
  endfunction

  // Physical memory behind the DUT, with a simple responder.
  logic [LW-1:0] pm [int];
  function automatic logic [LW-1:0] pm_rd(input int t);
    return pm.exists(t) ? pm[t] : init_line(t);
  endfunction

  int lat = 2, cur_lat, lat_cnt, rsp_tag;
  bit rand_lat = 0, held = 0;
  int rd_cnt = 0, wr_cnt = 0, last_rd_resp, last_wr_resp, rd_start_cyc, wr_start_cyc;
  logic [AW-1:0] h_addr;
  logic [LW-1:0] h_wdata;
  int            dr_tag_q[$];
  logic [LW-1:0] dr_data_q[$];

  initial begin
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0; held = 0;
      end else if (!rst && (pmem_read || pmem_write)) begin
        chk("pmem_rd_wr_excl", LW'(pmem_read & pmem_write), '0);
        if (held) begin
          chk("pmem_addr_stable", LW'(pmem_address), LW'(h_addr));
          chk("pmem_wdata_stable", pmem_wdata, h_wdata);
          lat_cnt++;
        end else begin
          held = 1; h_addr = pmem_address; h_wdata = pmem_wdata; lat_cnt = 0;
          cur_lat = rand_lat ? int'($urandom_range(0, 4)) : lat;
          chk("pmem_addr_offset0", LW'(pmem_address[OW-1:0]), '0);
          if (pmem_write) wr_start_cyc = cyc; else rd_start_cyc = cyc;
        end
        if (lat_cnt >= cur_lat) begin
          pmem_resp = 1'b1;
          rsp_tag = int'(pmem_address >> OW);
          if (pmem_read) begin
            pmem_rdata = pm_rd(rsp_tag); rd_cnt++; last_rd_resp = cyc;
          end else begin
            pm[rsp_tag] = pmem_wdata; dr_tag_q.push_back(rsp_tag); dr_data_q.push_back(pmem_wdata);
            wr_cnt++; last_wr_resp = cyc;
          end
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds the request until ul_resp is seen.
  task automatic up_req(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                        output logic [LW-1:0] rd, output int t_req, output int t_resp);
    ul_address = a; ul_wdata = d; ul_read = !wr; ul_write = wr;
    t_req = cyc; t_resp = -1; rd = '0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (ul_resp) begin rd = ul_rdata; t_resp = cyc; break; end
    end
    ul_read = 1'b0; ul_write = 1'b0;
    if (t_resp < 0) chk("ul_resp_timeout", '0, 1);
  endtask

  task automatic chk_drain(input int tag, input logic [LW-1:0] d);
    chk("drain_present", LW'(dr_tag_q.size() > 0), 1);
    if (dr_tag_q.size() > 0) begin
      chk("drain_tag", LW'(dr_tag_q.pop_front()), LW'(tag));
      chk("drain_data", dr_data_q.pop_front(), d);
    end
  endtask

  // Transaction-level model of the buffer and of memory contents.
  bit            mb_v;
  int            mb_tag;
  logic [LW-1:0] mb_data;
  logic [LW-1:0] mm [int];
  function automatic logic [LW-1:0] mm_rd(input int t);
    return mm.exists(t) ? mm[t] : init_line(t);
  endfunction

  initial begin
    logic [LW-1:0] rd, x, y, d, exp;
    int tq, tr, rc, wc, g, tag;
    bit wr;
    logic [AW-1:0] a;

    ul_read = 0; ul_write = 0; ul_address = '0; ul_wdata = '0;
    rst = 1'b1;
    idle(3);
    chk("rst_ul_resp", LW'(ul_resp), '0);
    chk("rst_pmem_read", LW'(pmem_read), '0);
    chk("rst_pmem_write", LW'(pmem_write), '0);
    chk("rst_pmem_address", LW'(pmem_address), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_ul_rdata", ul_rdata, '0);
    rst = 1'b0;
    idle(1);

    // Absorb on empty buffer, then idle drain timing.
    x = {$urandom, $urandom, $urandom, $urandom}; wc = wr_cnt;
    up_req(1, 16'h1230, x, rd, tq, tr);
    chk("absorb_lat", LW'(tr - tq), 1);
    chk("absorb_no_pmem_write", LW'(wr_cnt), LW'(wc));
    idle(12);
    chk("idle_drain_start", LW'(wr_start_cyc), LW'(tr + DI + 2));
    chk_drain(16'h123, x);

    // Read hit served from buffer.
    y = {$urandom, $urandom, $urandom, $urandom};
    idle(1); up_req(1, 16'h1230, y, rd, tq, tr);
    rc = rd_cnt;
    idle(1); up_req(0, 16'h123A, '0, rd, tq, tr);
    chk("hit_data", rd, y);
    chk("hit_lat", LW'(tr - tq), 1);
    chk("hit_no_pmem_read", LW'(rd_cnt), LW'(rc));
    idle(12); chk_drain(16'h123, y);

    // Read miss with buffer holding a dirty line: read goes first, drain later.
    x = {$urandom, $urandom, $urandom, $urandom};
    idle(1); up_req(1, 16'h1230, x, rd, tq, tr);
    wc = wr_cnt; lat = 5;
    idle(1); up_req(0, 16'h4000, '0, rd, tq, tr);
    chk("miss_data", rd, init_line(16'h400));
    chk("miss_read_start", LW'(rd_start_cyc), LW'(tq + 1));
    chk("miss_pmem_lat", LW'(last_rd_resp - rd_start_cyc), 5);
    chk("miss_lat", LW'(tr - last_rd_resp), 1);
    chk("miss_no_early_drain", LW'(wr_cnt), LW'(wc));
    lat = 2;
    idle(12);
    chk("miss_drain_start", LW'(wr_start_cyc), LW'(tr + DI + 2));
    chk_drain(16'h123, x);

    // Conflicting write drains old line, then absorbs.
    x = {$urandom, $urandom, $urandom, $urandom}; y = {$urandom, $urandom, $urandom, $urandom};
    idle(1); up_req(1, 16'h1230, x, rd, tq, tr);
    idle(1); up_req(1, 16'h5670, y, rd, tq, tr);
    chk_drain(16'h123, x);
    chk("conflict_lat", LW'(tr - last_wr_resp), 2);
    idle(12); chk_drain(16'h567, y);

    // Coalescing writes produce one drain with the latest data.
    x = {$urandom, $urandom, $urandom, $urandom}; y = {$urandom, $urandom, $urandom, $urandom};
    idle(1); up_req(1, 16'h1230, x, rd, tq, tr);
    idle(1); up_req(1, 16'h1234, y, rd, tq, tr);
    idle(12);
    chk("coalesce_drain_count", LW'(dr_tag_q.size()), 1);
    chk_drain(16'h123, y);

    // Reset during drain discards the line.
    d = {$urandom, $urandom, $urandom, $urandom};
    lat = 30;
    idle(1); up_req(1, 16'h1230, d, rd, tq, tr);
    g = 0;
    for (int w = 0; w < 20 && !pmem_write; w++) idle(1);
    chk("drain_before_rst", LW'(pmem_write), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drop_pmem_write", LW'(pmem_write), '0);
    chk("rst_drop_pmem_address", LW'(pmem_address), '0);
    chk("rst_drop_pmem_wdata", pmem_wdata, '0);
    chk("rst_drop_ul_resp", LW'(ul_resp), '0);
    idle(2);
    #2 rst = 1'b0;
    lat = 2; wc = wr_cnt;
    idle(15);
    chk("no_drain_after_rst", LW'(wr_cnt), LW'(wc));
    rc = rd_cnt;
    up_req(0, 16'h1230, '0, rd, tq, tr);
    chk("post_rst_miss", LW'(rd_cnt), LW'(rc + 1));
    chk("post_rst_data", rd, y);
    chk("post_rst_no_drains", LW'(dr_tag_q.size()), '0);

    // Random traffic on a disjoint tag range.
    rand_lat = 1; mb_v = 0;
    idle(1);
    for (int s = 0; s < 200; s++) begin
      g = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(1, 4));
      idle(g);
      if (g >= DI + 2 && mb_v) begin
        mm[mb_tag] = mb_data; mb_v = 0;
        chk_drain(mb_tag, mb_data);
      end
      wr = 1'($urandom_range(0, 1));
      tag = 16'h200 + int'($urandom_range(0, 3));
      a = AW'({tag[11:0], 4'($urandom)});
      d = {$urandom, $urandom, $urandom, $urandom};
      rc = rd_cnt;
      up_req(wr, a, d, rd, tq, tr);
      if (!wr) begin
        if (mb_v && mb_tag == tag) begin
          chk("r_hit_data", rd, mb_data);
          chk("r_hit_lat", LW'(tr - tq), 1);
          chk("r_hit_no_read", LW'(rd_cnt), LW'(rc));
        end else begin
          exp = mm_rd(tag);
          chk("r_miss_data", rd, exp);
          chk("r_miss_lat", LW'(tr - last_rd_resp), 1);
        end
      end else begin
        if (!mb_v || mb_tag == tag) begin
          chk("r_absorb_lat", LW'(tr - tq), 1);
        end else begin
          mm[mb_tag] = mb_data;
          chk_drain(mb_tag, mb_data);
          chk("r_conflict_lat", LW'(tr - last_wr_resp), 2);
        end
        mb_v = 1; mb_tag = tag; mb_data = d;
      end
      chk("r_no_extra_drain", LW'(dr_tag_q.size()), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
